// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer and multdiv handshake for the
//                        5-stage pipeline (load-use, control flush, multdiv).
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int TCNT_W     = 6,
    parameter int SCNT_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       insn_fd,
    input  logic [31:0]       insn_dx,
    input  logic              branch_taken,
    input  logic              md_ready,
    input  logic              md_exception,
    output logic              pc_we,
    output logic              fd_we,
    output logic              dx_we,
    output logic              fd_flush,
    output logic              dx_flush,
    output logic              xm_bubble,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic              md_busy,
    output logic              md_error,
    output logic [SCNT_W-1:0] stall_cycles
);

    localparam logic [4:0] C_OP_RTYPE = 5'b00000;
    localparam logic [4:0] C_OP_J     = 5'b00001;
    localparam logic [4:0] C_OP_BNE   = 5'b00010;
    localparam logic [4:0] C_OP_JAL   = 5'b00011;
    localparam logic [4:0] C_OP_JR    = 5'b00100;
    localparam logic [4:0] C_OP_ADDI  = 5'b00101;
    localparam logic [4:0] C_OP_BLT   = 5'b00110;
    localparam logic [4:0] C_OP_SW    = 5'b00111;
    localparam logic [4:0] C_OP_LW    = 5'b01000;
    localparam logic [4:0] C_OP_BEX   = 5'b10110;
    localparam logic [4:0] C_ALU_MUL  = 5'b00110;
    localparam logic [4:0] C_ALU_DIV  = 5'b00111;

    localparam logic [TCNT_W-1:0] C_TLAST = TCNT_W'(MD_TIMEOUT - 1);
    localparam logic [SCNT_W-1:0] C_SMAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                err_q, err_d;
    logic [SCNT_W-1:0]   stall_q;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
    logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;

    assign w_fd_op  = insn_fd[31:27];
    assign w_fd_rd  = insn_fd[26:22];
    assign w_fd_rs  = insn_fd[21:17];
    assign w_fd_rt  = insn_fd[16:12];
    assign w_dx_op  = insn_dx[31:27];
    assign w_dx_rd  = insn_dx[26:22];
    assign w_dx_alu = insn_dx[6:2];

    logic w_unused;
    assign w_unused = ^{insn_fd[11:0], insn_dx[21:7], insn_dx[1:0]};

    logic w_dx_mul, w_dx_div, w_dx_md;
    assign w_dx_mul = (w_dx_op == C_OP_RTYPE) && (w_dx_alu == C_ALU_MUL);
    assign w_dx_div = (w_dx_op == C_OP_RTYPE) && (w_dx_alu == C_ALU_DIV);
    assign w_dx_md  = w_dx_mul || w_dx_div;

    logic w_ctrl_xfer;
    assign w_ctrl_xfer = (w_dx_op == C_OP_J) || (w_dx_op == C_OP_JAL) ||
                         (w_dx_op == C_OP_JR) ||
                         (branch_taken && ((w_dx_op == C_OP_BNE) ||
                                           (w_dx_op == C_OP_BLT) ||
                                           (w_dx_op == C_OP_BEX)));

    // Which source register fields of the F/D instruction are actually read
    logic w_use_rs, w_use_rt, w_use_rd;
    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_use_rd = 1'b0;
        case (w_fd_op)
            C_OP_RTYPE: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            C_OP_ADDI, C_OP_LW: w_use_rs = 1'b1;
            C_OP_SW, C_OP_BNE, C_OP_BLT: begin
                w_use_rs = 1'b1;
                w_use_rd = 1'b1;
            end
            C_OP_JR: w_use_rd = 1'b1;
            default: ;
        endcase
    end

    logic w_load_use;
    assign w_load_use = (w_dx_op == C_OP_LW) && (w_dx_rd != 5'd0) &&
                        ((w_use_rs && (w_fd_rs == w_dx_rd)) ||
                         (w_use_rt && (w_fd_rt == w_dx_rd)) ||
                         (w_use_rd && (w_fd_rd == w_dx_rd)));

    // ------------------------------------------------------------------
    // Next-state and raw output decode
    // ------------------------------------------------------------------
    logic w_pc_we, w_fd_we, w_dx_we, w_fd_flush, w_dx_flush, w_xm_bubble;
    logic w_mult, w_div, w_busy, w_error;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        w_pc_we     = 1'b1;
        w_fd_we     = 1'b1;
        w_dx_we     = 1'b1;
        w_fd_flush  = 1'b0;
        w_dx_flush  = 1'b0;
        w_xm_bubble = 1'b0;
        w_mult      = 1'b0;
        w_div       = 1'b0;
        w_busy      = 1'b0;
        w_error     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_dx_md) begin
                    w_pc_we     = 1'b0;
                    w_fd_we     = 1'b0;
                    w_dx_we     = 1'b0;
                    w_xm_bubble = 1'b1;
                    w_busy      = 1'b1;
                    w_mult      = w_dx_mul;
                    w_div       = w_dx_div;
                    tcnt_d      = '0;
                    err_d       = 1'b0;
                    state_d     = S_BUSY;
                end else if (w_ctrl_xfer) begin
                    w_fd_flush = 1'b1;
                    w_dx_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_we    = 1'b0;
                    w_fd_we    = 1'b0;
                    w_dx_flush = 1'b1;
                end
            end
            S_BUSY: begin
                w_pc_we     = 1'b0;
                w_fd_we     = 1'b0;
                w_dx_we     = 1'b0;
                w_xm_bubble = 1'b1;
                w_busy      = 1'b1;
                tcnt_d      = tcnt_q + 1'b1;
                // A result arriving on the final allowed cycle beats the timeout
                if (md_ready) begin
                    err_d   = md_exception;
                    state_d = S_DONE;
                end else if (tcnt_q == C_TLAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_error = err_q;
                tcnt_d  = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                tcnt_d  = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc_we        = reset & w_pc_we;
    assign fd_we        = reset & w_fd_we;
    assign dx_we        = reset & w_dx_we;
    assign fd_flush     = reset & w_fd_flush;
    assign dx_flush     = reset & w_dx_flush;
    assign xm_bubble    = reset & w_xm_bubble;
    assign ctrl_MULT    = reset & w_mult;
    assign ctrl_DIV     = reset & w_div;
    assign md_busy      = reset & w_busy;
    assign md_error     = reset & w_error;
    assign stall_cycles = stall_q;

    // ------------------------------------------------------------------
    // State, timeout counter and stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            if (!w_pc_we && (stall_q != C_SMAX)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : randomized scoreboard bench for pipeline_hazard_ctrl
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;

    localparam int MD_TIMEOUT = 40;
    localparam int SCNT_W     = 32;

    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    // {pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble, MULT, DIV, busy, error}
    localparam logic [9:0] EXP_DEFAULT = 10'b1110000000;
    localparam logic [9:0] EXP_FLUSH   = 10'b1111100000;
    localparam logic [9:0] EXP_STALL   = 10'b0010100000;
    localparam logic [9:0] EXP_HOLD    = 10'b0000010010;
    localparam logic [9:0] EXP_MULT    = 10'b0000001000;
    localparam logic [9:0] EXP_DIV     = 10'b0000000100;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       insn_fd = '0;
    logic [31:0]       insn_dx = '0;
    logic              branch_taken = 1'b0;
    logic              md_ready = 1'b0;
    logic              md_exception = 1'b0;
    logic              pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble;
    logic              ctrl_MULT, ctrl_DIV, md_busy, md_error;
    logic [SCNT_W-1:0] stall_cycles;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(
        .MD_TIMEOUT(MD_TIMEOUT),
        .TCNT_W    (6),
        .SCNT_W    (SCNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .insn_fd     (insn_fd),
        .insn_dx     (insn_dx),
        .branch_taken(branch_taken),
        .md_ready    (md_ready),
        .md_exception(md_exception),
        .pc_we       (pc_we),
        .fd_we       (fd_we),
        .dx_we       (dx_we),
        .fd_flush    (fd_flush),
        .dx_flush    (dx_flush),
        .xm_bubble   (xm_bubble),
        .ctrl_MULT   (ctrl_MULT),
        .ctrl_DIV    (ctrl_DIV),
        .md_busy     (md_busy),
        .md_error    (md_error),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        bt;
        logic        rdy;
        logic        exc;
        logic [9:0]  exp;
    } cyc_t;

    typedef struct {
        logic [9:0]  exp;
        logic [31:0] stall;
    } sb_t;

    cyc_t        plan[$];
    sb_t         sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] model_stall = '0;

    function automatic logic [9:0] dut_out();
        return {pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble,
                ctrl_MULT, ctrl_DIV, md_busy, md_error};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] alu);
        return {OP_R, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [4:0] op);
        logic [31:0] rnd;
        rnd = $urandom;
        return {op, rnd[26:0]};
    endfunction

    function automatic logic [31:0] rand_insn(input bit allow_md);
        logic [4:0]  a, b, c;
        logic [31:0] rnd;
        int          k;
        a   = 5'($urandom_range(0, 7));
        b   = 5'($urandom_range(0, 7));
        c   = 5'($urandom_range(0, 7));
        rnd = $urandom;
        k   = $urandom_range(0, allow_md ? 14 : 12);
        case (k)
            0:       return 32'b0;
            1:       return mk_r(a, b, c, 5'($urandom_range(0, 5)));
            2:       return mk_i(OP_ADDI, a, b, rnd[16:0]);
            3, 4:    return mk_i(OP_LW, a, b, rnd[16:0]);
            5:       return mk_i(OP_SW, a, b, rnd[16:0]);
            6:       return mk_j(OP_J);
            7:       return mk_j(OP_JAL);
            8:       return mk_i(OP_JR, a, b, rnd[16:0]);
            9:       return mk_i(OP_BNE, a, b, rnd[16:0]);
            10:      return mk_i(OP_BLT, a, b, rnd[16:0]);
            11:      return mk_j(OP_BEX);
            12:      return mk_j(OP_SETX);
            13:      return mk_r(a, b, c, 5'd6);
            default: return mk_r(a, b, c, 5'd7);
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
        logic [4:0] op, rd, rs, rt;
        op = i[31:27]; rd = i[26:22]; rs = i[21:17]; rt = i[16:12];
        case (op)
            OP_R:                 return (rs == r) || (rt == r);
            OP_ADDI, OP_LW:       return rs == r;
            OP_SW, OP_BNE, OP_BLT: return (rs == r) || (rd == r);
            OP_JR:                return rd == r;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic bit is_md(input logic [31:0] i);
        return (i[31:27] == OP_R) && ((i[6:2] == 5'd6) || (i[6:2] == 5'd7));
    endfunction

    function automatic logic [9:0] expect_plain(input logic [31:0] fd, input logic [31:0] dx,
                                                input logic bt);
        logic [4:0] op;
        op = dx[31:27];
        if ((op inside {OP_J, OP_JAL, OP_JR}) || ((op inside {OP_BNE, OP_BLT, OP_BEX}) && bt))
            return EXP_FLUSH;
        if ((op == OP_LW) && (dx[26:22] != 5'd0) && reads(fd, dx[26:22]))
            return EXP_STALL;
        return EXP_DEFAULT;
    endfunction

    task automatic push_plain(input logic [31:0] fd, input logic [31:0] dx, input logic bt);
        cyc_t c;
        c.fd = fd; c.dx = dx; c.bt = bt;
        c.rdy = 1'($urandom); c.exc = 1'($urandom);
        c.exp = expect_plain(fd, dx, bt);
        plan.push_back(c);
    endtask

    // A multdiv op occupies one start cycle, a busy window that ends at the
    // result (latency L) or at the timeout, and one release cycle.
    task automatic gen_op(input logic [31:0] dx, input int lat, input logic exc);
        cyc_t c;
        int   nb;
        logic err;
        nb  = (lat <= MD_TIMEOUT) ? lat : MD_TIMEOUT;
        err = (lat <= MD_TIMEOUT) ? exc : 1'b1;
        c.dx = dx;
        c.fd = rand_insn(1); c.bt = 1'($urandom);
        c.rdy = 1'($urandom); c.exc = 1'($urandom);
        c.exp = EXP_HOLD | ((dx[6:2] == 5'd6) ? EXP_MULT : EXP_DIV);
        plan.push_back(c);
        for (int j = 1; j <= nb; j++) begin
            c.fd  = rand_insn(1); c.bt = 1'($urandom);
            c.rdy = (j == lat);
            c.exc = (j == lat) ? exc : 1'($urandom);
            c.exp = EXP_HOLD;
            plan.push_back(c);
        end
        c.fd = rand_insn(1); c.bt = 1'($urandom);
        c.rdy = 1'($urandom); c.exc = 1'($urandom);
        c.exp = EXP_DEFAULT | {9'b0, err};
        plan.push_back(c);
    endtask

    task automatic run_cycle(input cyc_t c);
        sb_t s;
        @(negedge clock);
        insn_fd = c.fd; insn_dx = c.dx; branch_taken = c.bt;
        md_ready = c.rdy; md_exception = c.exc;
        s.exp = c.exp; s.stall = model_stall;
        sb.push_back(s);
        if (!c.exp[9] && (model_stall != 32'hFFFF_FFFF)) model_stall = model_stall + 1;
    endtask

    task automatic run_plan();
        while (plan.size() > 0) run_cycle(plan.pop_front());
    endtask

    // ---------------- monitor ----------------
    initial begin
        sb_t s;
        forever begin
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                s = sb.pop_front();
                check("outputs", {22'b0, dut_out()}, {22'b0, s.exp});
                check("stall_cycles", stall_cycles, s.stall);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] dx;
        int          r, lat;

        #1 reset = 1'b0;
        @(negedge clock);
        #3;
        check("reset_outputs", {22'b0, dut_out()}, 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        reset = 1'b1;

        // load-use: lw $3,0($1) followed by add $4,$3,$2, then the bubble
        push_plain(mk_r(5'd4, 5'd3, 5'd2, 5'd0), mk_i(OP_LW, 5'd3, 5'd1, 17'd0), 1'b0);
        push_plain(mk_r(5'd4, 5'd3, 5'd2, 5'd0), 32'b0, 1'b0);
        push_plain(mk_r(5'd4, 5'd0, 5'd2, 5'd0), mk_i(OP_LW, 5'd0, 5'd1, 17'd0), 1'b0);
        // branch / jump flushes
        push_plain(32'b0, mk_i(OP_BNE, 5'd1, 5'd2, 17'd5), 1'b1);
        push_plain(32'b0, mk_i(OP_BNE, 5'd1, 5'd2, 17'd5), 1'b0);
        push_plain(32'b0, mk_j(OP_J), 1'b0);
        push_plain(32'b0, mk_j(OP_J), 1'b1);
        // multiply, divide-with-error back to back with multiply, timeout
        gen_op(mk_r(5'd5, 5'd1, 5'd2, 5'd6), 4, 1'b0);
        push_plain(32'b0, 32'b0, 1'b0);
        gen_op(mk_r(5'd6, 5'd1, 5'd2, 5'd7), 3, 1'b1);
        gen_op(mk_r(5'd7, 5'd1, 5'd2, 5'd6), 2, 1'b0);
        gen_op(mk_r(5'd7, 5'd1, 5'd2, 5'd6), 1000, 1'b0);
        push_plain(32'b0, 32'b0, 1'b0);
        run_plan();

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            dx = rand_insn(1);
            if (is_md(dx)) begin
                r = $urandom_range(0, 9);
                if (r < 7)       lat = $urandom_range(1, 10);
                else if (r == 7) lat = MD_TIMEOUT;
                else if (r == 8) lat = MD_TIMEOUT + 1;
                else             lat = 1000;
                gen_op(dx, lat, 1'($urandom));
            end else begin
                push_plain(rand_insn(1), dx, 1'($urandom));
            end
            run_plan();
        end

        // asynchronous reset in the middle of a busy period
        gen_op(mk_r(5'd3, 5'd1, 5'd2, 5'd6), 1000, 1'b0);
        for (int k = 0; k < 6; k++) run_cycle(plan.pop_front());
        plan.delete();
        #3 reset = 1'b0;
        #1;
        check("async_reset_outputs", {22'b0, dut_out()}, 32'd0);
        check("async_reset_stall", stall_cycles, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        insn_dx = 32'b0; insn_fd = 32'b0; md_ready = 1'b0;
        #3 reset = 1'b1;
        model_stall = '0;
        for (int k = 0; k < 3; k++) push_plain(32'b0, 32'b0, 1'b0);
        push_plain(mk_r(5'd4, 5'd3, 5'd2, 5'd0), mk_i(OP_LW, 5'd3, 5'd1, 17'd0), 1'b0);
        push_plain(32'b0, 32'b0, 1'b0);
        run_plan();

        repeat (3) @(negedge clock);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
